// File: rtl/dht11_read_scheduler.sv
// dht11_read_scheduler: serves DHT11 readings from cache or via a supervised, retried sensor transaction
module dht11_read_scheduler #(
    parameter int MIN_INTERVAL   = 100_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int MAX_RETRIES    = 2,
    parameter int RST_CYCLES     = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    input  logic [7:0] req_cmd_i,
    output logic       req_ready_o,
    output logic [7:0] sensor_enable_o,
    output logic       sensor_reset_o,
    input  logic       sensor_hold_i,
    input  logic       sensor_error_i,
    input  logic       sensor_done_i,
    input  logic [7:0] hum_int_i,
    input  logic [7:0] hum_float_i,
    input  logic [7:0] temp_int_i,
    input  logic [7:0] temp_float_i,
    output logic       resp_valid_o,
    output logic [7:0] resp_code_o,
    output logic [7:0] resp_data_o,
    input  logic       resp_ready_i,
    output logic       busy_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + RST_CYCLES + 2);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [26:0]   AGE_MAX   = 27'(MIN_INTERVAL);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {IDLE, DECODE, SRST, ARM, WAIT, FAIL, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [26:0]   age_q, age_d;
    logic          cache_valid_q, cache_valid_d;
    logic [7:0]    hum_int_q, hum_int_d, hum_float_q, hum_float_d;
    logic [7:0]    temp_int_q, temp_int_d, temp_float_q, temp_float_d;
    logic          resp_valid_q, resp_valid_d;
    logic [7:0]    resp_code_q, resp_code_d, resp_data_q, resp_data_d;
    logic          req_ready_q, req_ready_d;
    logic          unused_hold;

    // The transaction itself is supervised through done/error/timeout; hold is informational only.
    assign unused_hold = sensor_hold_i;

    function automatic logic [7:0] code_of(input logic [7:0] c);
        return c == 8'h00 ? 8'h1F : c == 8'h01 ? 8'h09 : c == 8'h02 ? 8'h08 :
               c == 8'h03 ? 8'h0A : c == 8'h04 ? 8'h0B : 8'hEE;
    endfunction

    function automatic logic [7:0] pick(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] hf,
                                        input logic [7:0] ti, input logic [7:0] tf);
        return c == 8'h01 ? ti : c == 8'h02 ? hi : c == 8'h03 ? tf : c == 8'h04 ? hf : 8'h00;
    endfunction

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_code_o     = resp_code_q;
    assign resp_data_o     = resp_data_q;
    assign sensor_enable_o = (state_q == SRST || state_q == ARM || state_q == WAIT) ? 8'h01 : 8'h00;
    assign sensor_reset_o  = state_q == SRST;
    assign busy_o          = state_q != IDLE;

    // Next-state logic: command decode, sensor sequencing with timeout/retry, cache and response handshake.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        age_d         = age_q == AGE_MAX ? age_q : age_q + 27'd1;
        cache_valid_d = cache_valid_q;
        hum_int_d     = hum_int_q;
        hum_float_d   = hum_float_q;
        temp_int_d    = temp_int_q;
        temp_float_d  = temp_float_q;
        resp_valid_d  = resp_valid_q;
        resp_code_d   = resp_code_q;
        resp_data_d   = resp_data_q;
        req_ready_d   = req_ready_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_q) begin
                cmd_d       = req_cmd_i;
                req_ready_d = 1'b0;
                state_d     = DECODE;
            end
            DECODE: if (cmd_q > 8'h04) begin
                resp_valid_d = 1'b1;
                resp_code_d  = 8'hEE;
                resp_data_d  = 8'h00;
                state_d      = RESPOND;
            end else if (cache_valid_q && age_q < AGE_MAX) begin
                resp_valid_d = 1'b1;
                resp_code_d  = code_of(cmd_q);
                resp_data_d  = pick(cmd_q, hum_int_q, hum_float_q, temp_int_q, temp_float_q);
                state_d      = RESPOND;
            end else begin
                retry_d = '0;
                cnt_d   = '0;
                state_d = SRST;
            end
            SRST: begin
                cnt_d = cnt_q == RST_LAST ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == RST_LAST ? ARM : SRST;
            end
            ARM: begin
                cnt_d = cnt_q == CW'(1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(1) ? WAIT : ARM;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sensor_done_i) begin
                    hum_int_d     = hum_int_i;
                    hum_float_d   = hum_float_i;
                    temp_int_d    = temp_int_i;
                    temp_float_d  = temp_float_i;
                    cache_valid_d = 1'b1;
                    age_d         = '0;
                    resp_valid_d  = 1'b1;
                    resp_code_d   = code_of(cmd_q);
                    resp_data_d   = pick(cmd_q, hum_int_i, hum_float_i, temp_int_i, temp_float_i);
                    state_d       = RESPOND;
                end else if (sensor_error_i || cnt_q == TO_LAST) begin
                    state_d = FAIL;
                end
            end
            FAIL: if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                cnt_d   = '0;
                state_d = SRST;
            end else begin
                cache_valid_d = 1'b0;
                resp_valid_d  = 1'b1;
                resp_code_d   = 8'hFF;
                resp_data_d   = 8'h00;
                state_d       = RESPOND;
            end
            RESPOND: if (resp_ready_i) begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset so the sensor is released immediately.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            cnt_q         <= '0;
            retry_q       <= '0;
            age_q         <= '0;
            cache_valid_q <= 1'b0;
            hum_int_q     <= '0;
            hum_float_q   <= '0;
            temp_int_q    <= '0;
            temp_float_q  <= '0;
            resp_valid_q  <= 1'b0;
            resp_code_q   <= '0;
            resp_data_q   <= '0;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            age_q         <= age_d;
            cache_valid_q <= cache_valid_d;
            hum_int_q     <= hum_int_d;
            hum_float_q   <= hum_float_d;
            temp_int_q    <= temp_int_d;
            temp_float_q  <= temp_float_d;
            resp_valid_q  <= resp_valid_d;
            resp_code_q   <= resp_code_d;
            resp_data_q   <= resp_data_d;
            req_ready_q   <= req_ready_d;
        end
    end
endmodule
